block_pixel_streamer: RTL and testbench

//  Buffers whole 8x8 colour blocks produced in one cycle by the colour-conversion

---
 rtl/block_pixel_streamer.sv | 88 ++++++++
 tb/tb_block_pixel_streamer.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/block_pixel_streamer.sv
// block_pixel_streamer: buffers whole 8x8 colour blocks and drains them as a backpressured raster pixel stream.
// Optional FRAME_LAST_EN adds frame_blocks/frame_last/blocks_out for end-of-frame marking.
module block_pixel_streamer #(
  parameter int PIX_W    = 8,
  parameter int CHANNELS = 3,
  parameter int DEPTH    = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [CHANNELS*64*PIX_W-1:0] blk_in,
  input  logic                         valid_in,
  output logic                         full,
  output logic                         overflow,
  output logic [CHANNELS*PIX_W-1:0]    pix_out,
  output logic                         pix_valid,
  input  logic                         pix_ready,
  output logic [2:0]                   pix_row,
  output logic [2:0]                   pix_col,
  output logic                         pix_last
`ifdef FRAME_LAST_EN
  ,
  input  logic [15:0]                  frame_blocks,
  output logic                         frame_last,
  output logic [15:0]                  blocks_out
`endif
);
  localparam int BW = CHANNELS*64*PIX_W;
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH+1);
  logic [BW-1:0] mem_q [DEPTH];
  logic [BW-1:0] cur;
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    row_q, row_d, col_q, col_d;
  logic          ovf_q, ovf_d, wr, take, ret;
  assign full      = cnt_q == CW'(DEPTH);
  assign pix_valid = cnt_q != '0;
  assign overflow  = ovf_q;
  assign pix_row   = row_q;
  assign pix_col   = col_q;
  assign pix_last  = pix_valid & (row_q == 3'd7) & (col_q == 3'd7);
  assign cur       = mem_q[rd_q];
  genvar c;
  for (c = 0; c < CHANNELS; c++) begin : g_ch
    assign pix_out[c*PIX_W +: PIX_W] = pix_valid ? cur[(c*64 + int'({row_q, col_q}))*PIX_W +: PIX_W] : '0;
  end
  always_comb begin
    wr    = valid_in & ~full;
    take  = pix_valid & pix_ready;
    ret   = take & pix_last;
    // a power-of-two DEPTH lets pointers wrap naturally; DEPTH==1 pins them at 0
    wr_d  = wr  ? wr_q + PW'(DEPTH > 1) : wr_q;
    rd_d  = ret ? rd_q + PW'(DEPTH > 1) : rd_q;
    cnt_d = cnt_q + CW'(wr) - CW'(ret);
    col_d = take ? col_q + 3'd1 : col_q;
    row_d = (take & (col_q == 3'd7)) ? row_q + 3'd1 : row_q;
    ovf_d = ovf_q | (valid_in & full);
  end
  always_ff @(posedge clk) begin
    if (wr) mem_q[wr_q] <= blk_in;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      row_q <= '0;
      col_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
      row_q <= row_d;
      col_q <= col_d;
      ovf_q <= ovf_d;
    end
  end
`ifdef FRAME_LAST_EN
  logic [15:0] bo_q;
  assign blocks_out = bo_q;
  assign frame_last = pix_last & (frame_blocks != 16'd0) & (bo_q == frame_blocks - 16'd1);
  always_ff @(posedge clk) begin
    if (rst) bo_q <= '0;
    else if (ret) bo_q <= frame_last ? 16'd0 : bo_q + 16'd1;
  end
`endif
endmodule

// File: tb/tb_block_pixel_streamer.sv
// tb_block_pixel_streamer: scoreboard bench; stimulus pushes expected beats, a negedge monitor pops and compares.
module tb_block_pixel_streamer;
  localparam int BW = 3*64*8;
  logic          clk = 1'b0, rst = 1'b1, valid_in = 1'b0, pix_ready = 1'b0;
  logic [BW-1:0] blk_in = '0;
  logic          full, overflow, pix_valid, pix_last;
  logic [23:0]   pix_out;
  logic [2:0]    pix_row, pix_col;
  logic [30:0]   exp_q [$];
  logic [30:0]   dword, prv;
  logic          prv_stall = 1'b0, full_seen = 1'b0;
  int            errs = 0, checks = 0, beats = 0, lasts = 0;
`ifdef FRAME_LAST_EN
  logic [15:0]   frame_blocks = '0, blocks_out, bo_exp = '0;
  logic          frame_last, fl_exp;
  int            fl_cnt = 0, fl_beat = 0;
`endif
  block_pixel_streamer dut (
    .clk(clk), .rst(rst), .blk_in(blk_in), .valid_in(valid_in), .full(full),
    .overflow(overflow), .pix_out(pix_out), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_row(pix_row), .pix_col(pix_col), .pix_last(pix_last)
`ifdef FRAME_LAST_EN
    , .frame_blocks(frame_blocks), .frame_last(frame_last), .blocks_out(blocks_out)
`endif
  );
  always #5 clk = ~clk;
  assign dword = {pix_last, pix_row, pix_col, pix_out};
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h", n, act, exp);
    end
  endtask
  function automatic logic [7:0] pv(int tag, int c, int i, int j);
    return 8'(c*64 + i*8 + j + tag*5);
  endfunction
  function automatic logic [BW-1:0] mk(int tag);
    logic [BW-1:0] b = '0;
    for (int c = 0; c < 3; c++)
      for (int i = 0; i < 8; i++)
        for (int j = 0; j < 8; j++) b[(c*64+i*8+j)*8 +: 8] = pv(tag, c, i, j);
    return b;
  endfunction
  task automatic push(int tag);
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++)
        exp_q.push_back({i == 7 && j == 7, 3'(i), 3'(j), pv(tag, 2, i, j), pv(tag, 1, i, j), pv(tag, 0, i, j)});
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic send(int tag, bit accept);
    valid_in = 1'b1;
    blk_in = mk(tag);
    if (accept) push(tag);
    step();
    valid_in = 1'b0;
  endtask
  task automatic drain(int budget);
    for (int k = 0; k < budget && exp_q.size() != 0; k++) step();
    step();
    chk("drain_empty", exp_q.size(), 0);
  endtask
  task automatic do_reset();
    rst = 1'b1;
    exp_q.delete();
    step();
    step();
    rst = 1'b0;
  endtask
  always @(negedge clk) begin
    if (rst) begin
      prv_stall = 1'b0;
`ifdef FRAME_LAST_EN
      bo_exp = '0;
`endif
    end else begin
      if (full) full_seen = 1'b1;
      if (prv_stall) begin
        chk("stall_valid", pix_valid, 1);
        chk("stall_hold", dword, prv);
      end
      if (pix_valid && pix_ready) begin
        if (exp_q.size() == 0) chk("unexpected_beat", dword, 0);
        else chk("beat", dword, exp_q.pop_front());
        beats++;
        if (pix_last) lasts++;
`ifdef FRAME_LAST_EN
        fl_exp = pix_last && frame_blocks != 0 && bo_exp == frame_blocks - 16'd1;
        chk("blocks_out", blocks_out, bo_exp);
        chk("frame_last", frame_last, fl_exp);
        if (frame_last) begin fl_cnt++; fl_beat = beats; end
        if (pix_last) bo_exp = fl_exp ? 16'd0 : bo_exp + 16'd1;
`endif
      end
      prv_stall = pix_valid && !pix_ready;
      prv = dword;
    end
  end
  initial begin
    int sent;
    step();
    step();
    rst = 1'b0;
    chk("rst_valid", pix_valid, 0);
    chk("rst_full", full, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_last", pix_last, 0);
    // single block, always ready: first pixel the cycle after acceptance
    pix_ready = 1'b1;
    send(0, 1);
    chk("lat_valid", pix_valid, 1);
    chk("lat_rowcol", {pix_row, pix_col}, 0);
    drain(200);
    chk("t1_beats", beats, 64);
    chk("t1_lasts", lasts, 1);
    chk("t1_full_seen", full_seen, 0);
    // three back-to-back blocks into a stalled consumer: third is dropped
    pix_ready = 1'b0;
    beats = 0;
    send(1, 1);
    chk("t2_not_full", full, 0);
    send(2, 1);
    chk("t2_full", full, 1);
    chk("t2_ovf_pre", overflow, 0);
    send(3, 0);
    chk("t2_ovf", overflow, 1);
    repeat (5) step();
    pix_ready = 1'b1;
    drain(300);
    chk("t2_beats", beats, 128);
    // random backpressure over eight blocks
    beats = 0;
    sent = 0;
    for (int k = 0; k < 3000 && (sent < 8 || exp_q.size() != 0); k++) begin
      pix_ready = 1'($urandom_range(0, 1));
      if (sent < 8 && !full) begin
        valid_in = 1'b1;
        blk_in = mk(20 + sent);
        push(20 + sent);
        sent++;
      end else valid_in = 1'b0;
      step();
    end
    valid_in = 1'b0;
    pix_ready = 1'b1;
    drain(100);
    chk("t3_beats", beats, 512);
    // write into a full buffer on the cycle block 0 retires is refused
    do_reset();
    pix_ready = 1'b0;
    send(10, 1);
    send(11, 1);
    chk("t4_full", full, 1);
    pix_ready = 1'b1;
    for (int k = 0; k < 100 && !(pix_valid && pix_row == 3'd7 && pix_col == 3'd7); k++) step();
    valid_in = 1'b1;
    blk_in = mk(12);
    step();
    valid_in = 1'b0;
    chk("t4_ovf", overflow, 1);
    chk("t4_full_after", full, 0);
    chk("t4_valid_after", pix_valid, 1);
    chk("t4_rowcol", {pix_row, pix_col}, 0);
    drain(200);
    // reset in the middle of a block
    beats = 0;
    send(40, 1);
    for (int k = 0; k < 100 && beats < 30; k++) step();
    chk("t5_mid", beats, 30);
    rst = 1'b1;
    exp_q.delete();
    step();
    rst = 1'b0;
    chk("t5_valid", pix_valid, 0);
    chk("t5_full", full, 0);
    chk("t5_ovf", overflow, 0);
    send(41, 1);
    chk("t5_restart", {pix_valid, pix_row, pix_col}, 7'b1000000);
    drain(200);
`ifdef FRAME_LAST_EN
    do_reset();
    frame_blocks = 16'd4;
    fl_cnt = 0;
    beats = 0;
    sent = 0;
    for (int k = 0; k < 1000 && sent < 5; k++) begin
      if (!full) begin send(50 + sent, 1); sent++; end
      else step();
    end
    drain(300);
    chk("t6_fl_cnt", fl_cnt, 1);
    chk("t6_fl_beat", fl_beat, 256);
    chk("t6_blocks_out", blocks_out, 1);
`endif
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
